// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared max defaults, restart FSM encodings and max toggle helper
package counter_ctrl_pkg;
    localparam logic [7:0] MAX_A_DEF = 8'd128;
    localparam logic [7:0] MAX_B_DEF = 8'd8;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;
    function automatic logic [7:0] next_max(input logic [7:0] cur, input logic [7:0] a, input logic [7:0] b);
        return (cur == a) ? b : a;
    endfunction
endpackage

// File: rtl/counter_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stable-level debouncer with a rising-level press pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES);
    logic [1:0] sync_q;
    logic stable_q, stable_d, done;
    logic [CW-1:0] cnt_q, cnt_d;
    // press is combinational so the consumer's register flips on the same edge stable does
    always_comb begin
        done = (sync_q[1] != stable_q) && (cnt_q == CW'(DEB_CYCLES - 1));
        stable_d = done ? sync_q[1] : stable_q;
        cnt_d = (sync_q[1] == stable_q || done) ? '0 : cnt_q + 1'b1;
        level = stable_q;
        press = done & sync_q[1];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            stable_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            stable_q <= stable_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: turns four raw buttons into direction, pause, max and a stretched counter reset
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int RST_HOLD = 4,
    parameter logic [7:0] MAX_A = MAX_A_DEF,
    parameter logic [7:0] MAX_B = MAX_B_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_dir,
    input  logic       btn_pause,
    input  logic       btn_mode,
    input  logic       btn_clr,
    output logic       direction,
    output logic       pause,
    output logic [7:0] max,
    output logic       ctr_rst
);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    logic [3:0] raw, prs, lvl_unused;
    logic restart;
    logic dir_q, dir_d, pause_q, pause_d, state_q, state_d;
    logic [7:0] max_q, max_d;
    logic [HW-1:0] hold_q, hold_d;
    assign raw = {btn_clr, btn_mode, btn_pause, btn_dir};
    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk),
            .rst(rst),
            .raw(raw[i]),
            .level(lvl_unused[i]),
            .press(prs[i])
        );
    end
    // mode and clr on the same edge merge into one restart
    assign restart = prs[2] | prs[3];
    always_comb begin
        dir_d = dir_q ^ prs[0];
        pause_d = pause_q ^ prs[1];
        max_d = prs[2] ? next_max(max_q, MAX_A, MAX_B) : max_q;
        state_d = restart ? ST_HOLD : (hold_q == '0) ? ST_IDLE : state_q;
        hold_d = restart ? HW'(RST_HOLD - 1) : (hold_q == '0) ? hold_q : hold_q - 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b1;
            pause_q <= 1'b0;
            max_q <= MAX_A;
            state_q <= ST_HOLD;
            hold_q <= HW'(RST_HOLD - 1);
        end else begin
            dir_q <= dir_d;
            pause_q <= pause_d;
            max_q <= max_d;
            state_q <= state_d;
            hold_q <= hold_d;
        end
    end
    assign direction = dir_q;
    assign pause = pause_q;
    assign max = max_q;
    assign ctr_rst = (state_q == ST_HOLD);
endmodule
